// File: rtl/alien_bomb.sv
// Enemy bomb: picks a live alien column, drops one bomb at a time down the playfield
// and reports a one-cycle pulse when it strikes the player ship.
module alien_bomb #(
    parameter int unsigned TICK_CYCLES    = 180000,
    parameter int unsigned COOLDOWN_TICKS = 6,
    parameter int unsigned NUM_COLS       = 8,
    parameter int unsigned COL_SPACING    = 3,
    parameter int unsigned SHIP_ROW       = 13,
    parameter int unsigned BOTTOM_ROW     = 14
) (
    input  logic                i_clk_36MHz,
    input  logic                i_reset_n,
    input  logic                i_enable,
    input  logic [NUM_COLS-1:0] i_alive_cols,
    input  logic [4:0]          i_swarm_x,
    input  logic [3:0]          i_swarm_bottom_y,
    input  logic [4:0]          i_ship_x,
    input  logic                i_hit,
    output logic [4:0]          o_bomb_x,
    output logic [3:0]          o_bomb_y,
    output logic                o_bomb_active,
    output logic                o_ship_hit
);

    localparam int unsigned TickW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int unsigned CoolW = $clog2(COOLDOWN_TICKS + 1);
    localparam int unsigned IdxW  = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam int unsigned ScanW = IdxW + 1;

    typedef enum logic [1:0] {
        StCooldown = 2'd0,
        StSelect   = 2'd1,
        StFalling  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [TickW-1:0]   tick_cnt_q;
    logic [CoolW-1:0]   cool_cnt_q, cool_cnt_d;
    logic [7:0]         lfsr_q;
    logic [IdxW-1:0]    idx_q, idx_d;
    logic [ScanW-1:0]   scan_q, scan_d;
    logic [4:0]         bomb_x_q, bomb_x_d;
    logic [3:0]         bomb_y_q, bomb_y_d;
    logic               active_q, active_d;
    logic               ship_hit_q, ship_hit_d;
    logic               tick;
    logic [4:0]         col_x;

    assign tick  = (tick_cnt_q == TickW'(TICK_CYCLES - 1));
    // Column x wraps mod 32 by truncation.
    assign col_x = i_swarm_x + 5'(32'(idx_q) * COL_SPACING);

    always_ff @(posedge i_clk_36MHz or negedge i_reset_n) begin
        if (!i_reset_n) begin
            tick_cnt_q <= '0;
        end else if (tick) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_q + TickW'(1);
        end
    end

    // Fibonacci LFSR, x^8+x^6+x^5+x^4+1, free-running.
    always_ff @(posedge i_clk_36MHz or negedge i_reset_n) begin
        if (!i_reset_n) begin
            lfsr_q <= 8'hA5;
        end else begin
            lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
    end

    always_ff @(posedge i_clk_36MHz or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= StCooldown;
            cool_cnt_q <= '0;
            idx_q      <= '0;
            scan_q     <= '0;
            bomb_x_q   <= 5'd0;
            bomb_y_q   <= 4'd15;
            active_q   <= 1'b0;
            ship_hit_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cool_cnt_q <= cool_cnt_d;
            idx_q      <= idx_d;
            scan_q     <= scan_d;
            bomb_x_q   <= bomb_x_d;
            bomb_y_q   <= bomb_y_d;
            active_q   <= active_d;
            ship_hit_q <= ship_hit_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cool_cnt_d = cool_cnt_q;
        idx_d      = idx_q;
        scan_d     = scan_q;
        bomb_x_d   = bomb_x_q;
        bomb_y_d   = bomb_y_q;
        active_d   = active_q;
        ship_hit_d = 1'b0;

        unique case (state_q)
            StCooldown: begin
                if (cool_cnt_q == CoolW'(COOLDOWN_TICKS)) begin
                    if (i_enable) begin
                        idx_d      = lfsr_q[IdxW-1:0];
                        scan_d     = '0;
                        cool_cnt_d = '0;
                        state_d    = StSelect;
                    end
                end else if (tick) begin
                    cool_cnt_d = cool_cnt_q + CoolW'(1);
                end
            end
            StSelect: begin
                if (i_alive_cols[idx_q]) begin
                    if (i_swarm_bottom_y < 4'(BOTTOM_ROW)) begin
                        bomb_x_d = col_x;
                        bomb_y_d = i_swarm_bottom_y + 4'd1;
                        active_d = 1'b1;
                        state_d  = StFalling;
                    end else begin
                        state_d = StCooldown;
                    end
                end else begin
                    idx_d  = idx_q + IdxW'(1);
                    scan_d = scan_q + ScanW'(1);
                    if (scan_q == ScanW'(NUM_COLS - 1)) begin
                        state_d = StCooldown;
                    end
                end
            end
            StFalling: begin
                // External destruction wins over a simultaneous ship overlap.
                if (i_hit) begin
                    bomb_x_d = 5'd0;
                    bomb_y_d = 4'd15;
                    active_d = 1'b0;
                    state_d  = StCooldown;
                end else if (bomb_y_q == 4'(SHIP_ROW) && bomb_x_q == i_ship_x) begin
                    ship_hit_d = 1'b1;
                    bomb_x_d   = 5'd0;
                    bomb_y_d   = 4'd15;
                    active_d   = 1'b0;
                    state_d    = StCooldown;
                end else if (tick && bomb_y_q == 4'(BOTTOM_ROW)) begin
                    bomb_x_d = 5'd0;
                    bomb_y_d = 4'd15;
                    active_d = 1'b0;
                    state_d  = StCooldown;
                end else if (tick) begin
                    bomb_y_d = bomb_y_q + 4'd1;
                end
            end
            default: begin
                bomb_x_d   = 5'd0;
                bomb_y_d   = 4'd15;
                active_d   = 1'b0;
                cool_cnt_d = '0;
                state_d    = StCooldown;
            end
        endcase
    end

    assign o_bomb_x      = bomb_x_q;
    assign o_bomb_y      = bomb_y_q;
    assign o_bomb_active = active_q;
    assign o_ship_hit    = ship_hit_q;

endmodule
